// File: rtl/chip8_loader_pkg.sv
// Shared constants for the Chip-8 program loader: RAM map and loader FSM encodings.
package chip8_loader_pkg;

  localparam logic [11:0] CHIP8_PROG_BASE = 12'h200;
  localparam logic [11:0] CHIP8_RAM_TOP   = 12'hFFF;

  typedef logic [1:0] loader_state_t;

  localparam loader_state_t StIdle  = 2'd0;
  localparam loader_state_t StLoad  = 2'd1;
  localparam loader_state_t StClear = 2'd2;
  localparam loader_state_t StReset = 2'd3;

  function automatic logic [12:0] max13(input logic [12:0] a, input logic [12:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/chip8_loader_sync_edge.sv
// Multi-stage synchroniser for an asynchronous level, with registered one-cycle
// rise and fall pulses taken from the synchronised value.
module chip8_loader_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
      rise_q <= sync_q[Stages-1] & ~prev_q;
      fall_q <= ~sync_q[Stages-1] & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/chip8_loader.sv
// Writes an uploaded program into Chip-8 RAM, zero-fills the rest, then pulses a
// stretched CPU reset and a done strobe; the CPU is held throughout.
module chip8_loader
  import chip8_loader_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR   = CHIP8_PROG_BASE,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RES_LEN     = 16
) (
  input  logic        clk,
  input  logic        res,
  input  logic        uploading,
  input  logic        upload_en,
  input  logic [11:0] upload_a,
  input  logic [7:0]  upload_d,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_d,
  output logic        cpu_hold,
  output logic        res_out,
  output logic        done,
  output logic        overflow,
  output logic [12:0] byte_count,
  output logic [7:0]  checksum
);

  localparam int unsigned CntW = $clog2(RES_LEN + 1);
  localparam logic [CntW-1:0] ResLast = CntW'(RES_LEN - 1);

  logic up_rise, up_fall, en_rise, en_fall_unused;

  chip8_loader_sync_edge #(.Stages(SYNC_STAGES)) u_sync_up (
    .clk_i  (clk),
    .rst_i  (res),
    .d_i    (uploading),
    .rise_o (up_rise),
    .fall_o (up_fall)
  );

  chip8_loader_sync_edge #(.Stages(SYNC_STAGES)) u_sync_en (
    .clk_i  (clk),
    .rst_i  (res),
    .d_i    (upload_en),
    .rise_o (en_rise),
    .fall_o (en_fall_unused)
  );

  loader_state_t   state_q, state_d;
  logic [12:0]     hi_addr_q, hi_addr_d;
  logic            pend_q, pend_d;
  logic [CntW-1:0] res_cnt_q, res_cnt_d;
  logic            mem_we_q, mem_we_d;
  logic [11:0]     mem_addr_q, mem_addr_d;
  logic [7:0]      mem_d_q, mem_d_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            res_out_q, res_out_d;
  logic            done_q, done_d;
  logic            overflow_q, overflow_d;
  logic [12:0]     byte_count_q, byte_count_d;
  logic [7:0]      checksum_q, checksum_d;
  logic [12:0]     sum;
  logic            start_load;

  always_comb begin
    state_d      = state_q;
    hi_addr_d    = hi_addr_q;
    pend_d       = pend_q;
    res_cnt_d    = res_cnt_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_d_d      = mem_d_q;
    cpu_hold_d   = cpu_hold_q;
    res_out_d    = res_out_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;
    byte_count_d = byte_count_q;
    checksum_d   = checksum_q;
    start_load   = 1'b0;
    sum          = {1'b0, BASE_ADDR} + {1'b0, upload_a};

    case (state_q)
      StIdle: start_load = up_rise;
      StLoad: begin
        if (pend_q) begin
          state_d = StClear;
          pend_d  = 1'b0;
        end else begin
          if (en_rise) begin
            byte_count_d = (byte_count_q == 13'h1FFF) ? byte_count_q : byte_count_q + 13'd1;
            checksum_d   = checksum_q + upload_d;
            if (!sum[12]) begin
              mem_we_d   = 1'b1;
              mem_addr_d = sum[11:0];
              mem_d_d    = upload_d;
              hi_addr_d  = max13(hi_addr_q, sum + 13'd1);
            end else begin
              overflow_d = 1'b1;
            end
          end
          // A byte landing with the end of upload is written before leaving LOAD.
          if (up_fall) begin
            if (en_rise) pend_d = 1'b1;
            else         state_d = StClear;
          end
        end
      end
      StClear: begin
        if (up_rise) begin
          start_load = 1'b1;
        end else if (hi_addr_q[12]) begin
          state_d   = StReset;
          res_out_d = 1'b1;
          res_cnt_d = '0;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = hi_addr_q[11:0];
          mem_d_d    = 8'h00;
          hi_addr_d  = hi_addr_q + 13'd1;
          if (hi_addr_q[11:0] == CHIP8_RAM_TOP) begin
            state_d   = StReset;
            res_out_d = 1'b1;
            res_cnt_d = '0;
          end
        end
      end
      StReset: begin
        if (up_rise) begin
          start_load = 1'b1;
        end else if (res_cnt_q == ResLast) begin
          state_d    = StIdle;
          res_out_d  = 1'b0;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else begin
          res_cnt_d = res_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_load) begin
      state_d      = StLoad;
      byte_count_d = '0;
      checksum_d   = '0;
      overflow_d   = 1'b0;
      hi_addr_d    = {1'b0, BASE_ADDR};
      cpu_hold_d   = 1'b1;
      res_out_d    = 1'b0;
      pend_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= StIdle;
      hi_addr_q    <= {1'b0, BASE_ADDR};
      pend_q       <= 1'b0;
      res_cnt_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_d_q      <= '0;
      cpu_hold_q   <= 1'b0;
      res_out_q    <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      hi_addr_q    <= hi_addr_d;
      pend_q       <= pend_d;
      res_cnt_q    <= res_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_d_q      <= mem_d_d;
      cpu_hold_q   <= cpu_hold_d;
      res_out_q    <= res_out_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
      checksum_q   <= checksum_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_d      = mem_d_q;
  assign cpu_hold   = cpu_hold_q;
  assign res_out    = res_out_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_chip8_loader.sv
// Scoreboard bench for chip8_loader: expected RAM writes are queued as stimulus is
// driven and popped as the loader emits them.
module tb_chip8_loader;

  localparam int unsigned RES_LEN = 16;

  logic        clk = 1'b0;
  logic        res, uploading, upload_en;
  logic [11:0] upload_a;
  logic [7:0]  upload_d;
  logic        mem_we, cpu_hold, res_out, done, overflow;
  logic [11:0] mem_addr;
  logic [7:0]  mem_d, checksum;
  logic [12:0] byte_count;

  always #5 clk = ~clk;

  chip8_loader #(
    .BASE_ADDR   (12'h200),
    .SYNC_STAGES (2),
    .RES_LEN     (RES_LEN)
  ) dut (
    .clk        (clk),
    .res        (res),
    .uploading  (uploading),
    .upload_en  (upload_en),
    .upload_a   (upload_a),
    .upload_d   (upload_d),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_d      (mem_d),
    .cpu_hold   (cpu_hold),
    .res_out    (res_out),
    .done       (done),
    .overflow   (overflow),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [19:0] sb_q[$];
  logic [19:0] exp_w;
  int          writes_total = 0, res_hi_total = 0, done_total = 0;
  int          res_run = 0, last_run = 0, cyc = 0;
  logic        prev_res = 1'b0, was_res;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we) begin
      writes_total++;
      if (sb_q.size() == 0) begin
        check_eq("write_unexpected", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_w = sb_q.pop_front();
        check_eq("write", {12'h0, mem_addr, mem_d}, {12'h0, exp_w});
      end
    end
    was_res = prev_res;
    if (res_out) begin
      res_hi_total++;
      res_run++;
    end else if (prev_res) begin
      last_run = res_run;
      res_run  = 0;
    end
    prev_res = res_out;
    if (done) begin
      done_total++;
      check_eq("res_len", 32'(last_run), 32'(RES_LEN));
      check_eq("done_after_res", 32'(was_res), 32'd1);
      check_eq("done_hold", 32'(cpu_hold), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [11:0] off, input logic [7:0] d);
    logic [12:0] s;
    s = {1'b0, 12'h200} + {1'b0, off};
    if (!s[12]) sb_q.push_back({s[11:0], d});
  endtask

  task automatic push_fill(input int from);
    for (int a = from; a <= 32'hFFF; a++) sb_q.push_back({a[11:0], 8'h00});
  endtask

  task automatic send_byte(input logic [11:0] off, input logic [7:0] d, input bit drop_up);
    tick(1);
    upload_a  = off;
    upload_d  = d;
    upload_en = 1'b1;
    if (drop_up) uploading = 1'b0;
    tick(2);
    upload_en = 1'b0;
    tick(4);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int d0;
    d0 = done_total;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (done_total != d0) break;
    end
    check_eq(tag, 32'(done_total - d0), 32'd1);
  endtask

  int w0, r0, d0, c0;

  initial begin
    res = 1'b1; uploading = 1'b0; upload_en = 1'b0; upload_a = '0; upload_d = '0;
    tick(3);
    res = 1'b0;
    tick(1);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check_eq("rst_res_out", 32'(res_out), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_byte_count", 32'(byte_count), 32'd0);
    check_eq("rst_checksum", 32'(checksum), 32'd0);

    // Strobes while idle are ignored
    w0 = writes_total;
    for (int i = 0; i < 3; i++) send_byte(12'(i), 8'h5A, 1'b0);
    check_eq("idle_writes", 32'(writes_total - w0), 32'd0);
    check_eq("idle_byte_count", 32'(byte_count), 32'd0);

    // Three-byte program with full zero fill
    w0 = writes_total; r0 = res_hi_total;
    uploading = 1'b1;
    tick(6);
    check_eq("t1_cpu_hold", 32'(cpu_hold), 32'd1);
    expect_write(12'h000, 8'hA2);
    tick(1);
    upload_a = 12'h000; upload_d = 8'hA2; upload_en = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_we) break;
    end
    check_eq("we_latency", 32'(cyc - c0), 32'd4);
    tick(1);
    upload_en = 1'b0;
    tick(4);
    expect_write(12'h001, 8'h1E);
    send_byte(12'h001, 8'h1E, 1'b0);
    expect_write(12'h002, 8'hF0);
    send_byte(12'h002, 8'hF0, 1'b0);
    push_fill(32'h203);
    tick(1);
    uploading = 1'b0;
    wait_done("t1_done", 5000);
    check_eq("t1_writes", 32'(writes_total - w0), 32'd3584);
    check_eq("t1_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("t1_byte_count", 32'(byte_count), 32'd3);
    check_eq("t1_checksum", 32'(checksum), 32'hB0);
    check_eq("t1_overflow", 32'(overflow), 32'd0);
    check_eq("t1_res_cycles", 32'(res_hi_total - r0), 32'(RES_LEN));

    w0 = writes_total;
    for (int i = 0; i < 2; i++) send_byte(12'h010, 8'h01, 1'b0);
    check_eq("idle2_writes", 32'(writes_total - w0), 32'd0);
    check_eq("idle2_byte_count", 32'(byte_count), 32'd3);

    // Overflowing byte dropped, last byte at top of RAM, no fill
    w0 = writes_total; r0 = res_hi_total;
    uploading = 1'b1;
    tick(6);
    expect_write(12'hE00, 8'h55);
    send_byte(12'hE00, 8'h55, 1'b0);
    expect_write(12'hDFF, 8'h66);
    send_byte(12'hDFF, 8'h66, 1'b0);
    tick(1);
    uploading = 1'b0;
    wait_done("t2_done", 200);
    check_eq("t2_writes", 32'(writes_total - w0), 32'd1);
    check_eq("t2_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("t2_overflow", 32'(overflow), 32'd1);
    check_eq("t2_byte_count", 32'(byte_count), 32'd2);
    check_eq("t2_checksum", 32'(checksum), 32'hBB);
    check_eq("t2_res_cycles", 32'(res_hi_total - r0), 32'(RES_LEN));

    // Last byte edge coincides with uploading fall
    w0 = writes_total;
    uploading = 1'b1;
    tick(6);
    expect_write(12'h000, 8'h11);
    send_byte(12'h000, 8'h11, 1'b0);
    expect_write(12'h001, 8'h22);
    push_fill(32'h202);
    send_byte(12'h001, 8'h22, 1'b1);
    wait_done("t3_done", 5000);
    check_eq("t3_writes", 32'(writes_total - w0), 32'd3584);
    check_eq("t3_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("t3_byte_count", 32'(byte_count), 32'd2);
    check_eq("t3_checksum", 32'(checksum), 32'h33);

    // Re-upload during fill aborts the sequence
    uploading = 1'b1;
    tick(6);
    expect_write(12'h000, 8'h77);
    send_byte(12'h000, 8'h77, 1'b0);
    push_fill(32'h201);
    tick(1);
    uploading = 1'b0;
    tick(40);
    r0 = res_hi_total; d0 = done_total;
    uploading = 1'b1;
    tick(6);
    w0 = writes_total;
    tick(20);
    check_eq("t4_fill_stopped", 32'(writes_total - w0), 32'd0);
    check_eq("t4_fill_partial", 32'(sb_q.size() > 3000), 32'd1);
    sb_q.delete();
    check_eq("t4_res_never", 32'(res_hi_total - r0), 32'd0);
    check_eq("t4_no_done", 32'(done_total - d0), 32'd0);
    check_eq("t4_cpu_hold", 32'(cpu_hold), 32'd1);
    check_eq("t4_byte_count", 32'(byte_count), 32'd0);

    // Reset asserted while res_out is high
    expect_write(12'hDFF, 8'h99);
    send_byte(12'hDFF, 8'h99, 1'b0);
    check_eq("t5_byte_count", 32'(byte_count), 32'd1);
    tick(1);
    uploading = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_out) break;
    end
    check_eq("t5_res_seen", 32'(res_out), 32'd1);
    tick(3);
    res = 1'b1;
    tick(1);
    res = 1'b0;
    check_eq("t5_res_out", 32'(res_out), 32'd0);
    check_eq("t5_cpu_hold", 32'(cpu_hold), 32'd0);
    check_eq("t5_mem_we", 32'(mem_we), 32'd0);
    check_eq("t5_byte_count", 32'(byte_count), 32'd0);
    d0 = done_total; w0 = writes_total;
    tick(40);
    check_eq("t5_no_done", 32'(done_total - d0), 32'd0);
    check_eq("t5_no_writes", 32'(writes_total - w0), 32'd0);
    check_eq("t5_res_low", 32'(res_out), 32'd0);
    check_eq("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
